dcache_stall_ctrl: RTL and testbench
====================================

DCACHE_STALL_CTRL -- requirements
Module: dcache_stall_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the performance counters.
REQ-002 clk_i  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 access_i  input  1  MEM-stage load or store valid (MemRead_EXMEM | MemWrite_EXMEM).
REQ-005 hit_i  input  1  cache tag match and valid for the current MEM-stage address.
REQ-006 dirty_i  input  1  victim line dirty for the current MEM-stage address.
REQ-007 mem_ack_i  input  1  single-cycle pulse from data memory; completes the outstanding request.
REQ-008 mem_req_o  output  1  data-memory request valid.
REQ-009 mem_we_o  output  1  request type: 1 = write-back of victim, 0 = line fetch.
REQ-010 cache_we_o  output  1  write fetched line into cache SRAM this cycle.
REQ-011 stall_o  output  1  freeze PC and all pipeline registers this cycle.
REQ-012 miss_cnt_o  output  CNT_W  count of misses detected.
REQ-013 stall_cnt_o  output  CNT_W  count of cycles with stall_o = 1.

Function
REQ-014 The FSM SHALL have four states: IDLE, WB (write-back), RF (refill), RESUME.
REQ-015 In IDLE, a miss SHALL be the condition access_i = 1 and hit_i = 0.
REQ-016 In IDLE, on a miss, the FSM SHALL go to WB if dirty_i = 1, else to RF.
REQ-017 In IDLE, on no miss, the FSM SHALL stay in IDLE.
REQ-018 In IDLE, stall_o SHALL equal the miss condition combinationally, so the missing instruction never leaves MEM.
REQ-019 stall_o SHALL be 1 in every cycle spent in WB, RF or RESUME.
REQ-020 In WB: mem_req_o = 1 and mem_we_o = 1; on mem_ack_i = 1 the FSM SHALL go to RF.
REQ-021 In RF: mem_req_o = 1 and mem_we_o = 0; on mem_ack_i = 1 the FSM SHALL go to RESUME.
REQ-022 In RF, cache_we_o SHALL equal mem_ack_i, so the refill write occurs exactly in the ack cycle.
REQ-023 cache_we_o SHALL be 0 in every other state.
REQ-024 mem_req_o SHALL stay high without gaps until ack.
REQ-025 WB-to-RF is back-to-back: mem_req_o stays 1 and mem_we_o changes 1 to 0 in the cycle after the WB ack.
REQ-026 RESUME SHALL last exactly one cycle; the cache re-reads, and the FSM returns to IDLE unconditionally.
REQ-027 access_i, hit_i and dirty_i SHALL be ignored outside IDLE.
REQ-028 mem_ack_i SHALL be ignored in IDLE and RESUME.
REQ-029 The FSM SHALL NOT time out; it waits indefinitely for mem_ack_i.
REQ-030 In IDLE and RESUME, mem_req_o, mem_we_o and cache_we_o SHALL be 0.
REQ-031 Miss latency SHALL be N_wb + N_rf + 2 stalled cycles, where N_wb and N_rf are the cycles spent in WB and RF, with N_wb = 0 for a clean miss.

Reset
REQ-032 rst_i = 1 SHALL immediately force state IDLE and both counters to 0, independent of clk_i.
REQ-033 While rst_i = 1, mem_req_o, mem_we_o, cache_we_o and stall_o SHALL be 0.
REQ-034 Reset mid-operation SHALL abandon any outstanding request; a late mem_ack_i after reset is ignored.

Configuration
REQ-035 Macro STALL_PERF_CNT_EN defined: miss_cnt_o SHALL increment on each IDLE-to-WB and each IDLE-to-RF transition.
REQ-036 Macro STALL_PERF_CNT_EN defined: stall_cnt_o SHALL increment on each clock edge where stall_o = 1.
REQ-037 Macro STALL_PERF_CNT_EN defined: both counters SHALL saturate at 2^CNT_W - 1.
REQ-038 Macro STALL_PERF_CNT_EN undefined: ports miss_cnt_o and stall_cnt_o SHALL still exist, tied to 0, with no counter flops.

Verification
REQ-039 Hit: access_i = 1, hit_i = 1 for 5 cycles -> stall_o = 0 and mem_req_o = 0 throughout.
REQ-040 Clean miss, ack 3 cycles after entering RF -> stall_o high 5 cycles, mem_we_o = 0, one cache_we_o pulse aligned with the ack, then IDLE.
REQ-041 Dirty miss, WB ack after 2 cycles, RF ack after 2 cycles -> mem_we_o 1,1 then 0,0 with mem_req_o continuous, stall_o high 6 cycles.
REQ-042 rst_i asserted mid-cycle while in RF -> outputs 0 asynchronously; a following mem_ack_i produces no cache_we_o.
REQ-043 STALL_PERF_CNT_EN defined, CNT_W = 4, 20 clean misses each with an immediate ack -> miss_cnt_o = 15 and stall_cnt_o = 15 (saturated).
REQ-044 STALL_PERF_CNT_EN undefined, same stimulus as REQ-043 -> both counters read 0.

Source files
------------

// File: rtl/dcache_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dcache_stall_ctrl
//  Description : Data-cache miss controller. Detects a MEM-stage miss, stalls
//                the pipeline, optionally writes back the dirty victim, then
//                refills the line and re-reads it before releasing the stall.
//                Optional feature macro: STALL_PERF_CNT_EN enables the
//                saturating miss / stall-cycle performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             access_i,
    input  logic             hit_i,
    input  logic             dirty_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             cache_we_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wb     = 2'd1;
    localparam logic [1:0] c_st_rf     = 2'd2;
    localparam logic [1:0] c_st_resume = 2'd3;

    logic [1:0] r_state;
    logic       w_miss;
    logic       w_miss_evt;

    // A miss is only meaningful while waiting for new MEM-stage accesses.
    assign w_miss     = access_i & ~hit_i;
    assign w_miss_evt = (r_state == c_st_idle) & w_miss;

    // Miss-handling state machine; waits indefinitely for each memory ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_miss) begin
                        r_state <= dirty_i ? c_st_wb : c_st_rf;
                    end
                end
                c_st_wb: begin
                    if (mem_ack_i) begin
                        r_state <= c_st_rf;
                    end
                end
                c_st_rf: begin
                    if (mem_ack_i) begin
                        r_state <= c_st_resume;
                    end
                end
                c_st_resume: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Output decode. The IDLE stall follows the miss combinationally so the
    // missing instruction never leaves MEM; everything is held low in reset.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        cache_we_o = 1'b0;
        stall_o    = 1'b0;
        if (!rst_i) begin
            case (r_state)
                c_st_idle: begin
                    stall_o = w_miss;
                end
                c_st_wb: begin
                    stall_o   = 1'b1;
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                end
                c_st_rf: begin
                    stall_o    = 1'b1;
                    mem_req_o  = 1'b1;
                    cache_we_o = mem_ack_i;
                end
                c_st_resume: begin
                    stall_o = 1'b1;
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_miss_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating counters: misses detected and cycles spent stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_miss_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_miss_evt && (r_miss_cnt != c_cnt_max)) begin
                r_miss_cnt <= r_miss_cnt + c_cnt_one;
            end
            if (stall_o && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
        end
    end

    assign miss_cnt_o  = r_miss_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    // Counters compiled out: ports remain, tied off.
    assign miss_cnt_o  = '0;
    assign stall_cnt_o = '0;

    logic w_unused;
    assign w_unused = w_miss_evt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_stall_ctrl
//  Description : Self-checking bench for dcache_stall_ctrl. Expected behaviour
//                is derived per miss from its shape (dirty, WB/RF lengths) as
//                a per-cycle trace, with saturating counter totals.
//                Honours STALL_PERF_CNT_EN for the counter expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_stall_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             access_i;
    logic             hit_i;
    logic             dirty_i;
    logic             mem_ack_i;
    logic             mem_req_o;
    logic             mem_we_o;
    logic             cache_we_o;
    logic             stall_o;
    logic [CNT_W-1:0] miss_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int checks    = 0;
    int errors    = 0;
    int exp_miss  = 0;
    int exp_stall = 0;

    dcache_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .access_i    (access_i),
        .hit_i       (hit_i),
        .dirty_i     (dirty_i),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .cache_we_o  (cache_we_o),
        .stall_o     (stall_o),
        .miss_cnt_o  (miss_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference counter step: saturating when counters exist, else always 0.
    function automatic int sat_inc(input int v);
`ifdef STALL_PERF_CNT_EN
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
`else
        return 0 * v;
`endif
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_i = 1'b1; access_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        exp_miss  = 0;
        exp_stall = 0;
    endtask

    // Non-miss cycles in IDLE: no stall, no memory traffic, counters steady.
    task automatic do_idle(input int n, input bit force_hit, input string tag);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            access_i  = force_hit ? 1'b1 : 1'($urandom % 2);
            hit_i     = (access_i == 1'b1) ? 1'b1 : 1'($urandom % 2);
            dirty_i   = 1'($urandom % 2);
            mem_ack_i = 1'($urandom % 2);
            #2;
            checks++;
            if ({mem_req_o, mem_we_o, cache_we_o, stall_o} !== 4'b0000) begin
                errors++;
                $display("FAIL %s idle cyc %0d: req/we/cwe/stall got %b%b%b%b want 0000",
                         tag, c, mem_req_o, mem_we_o, cache_we_o, stall_o);
            end
            checks++;
            if ((int'(miss_cnt_o) !== exp_miss) || (int'(stall_cnt_o) !== exp_stall)) begin
                errors++;
                $display("FAIL %s idle counters: got miss %0d stall %0d want %0d %0d",
                         tag, miss_cnt_o, stall_cnt_o, exp_miss, exp_stall);
            end
        end
    endtask

    // One complete miss: IDLE detect cycle, nwb WB cycles (dirty only),
    // nrf RF cycles with the ack in the last one, then one RESUME cycle.
    task automatic do_miss(input bit d, input int nwb, input int nrf, input bit junk,
                           input string tag);
        int  nw;
        int  total;
        bit  e_req, e_we, e_cwe;
        nw    = d ? nwb : 0;
        total = 2 + nw + nrf;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            e_req = 1'b0; e_we = 1'b0; e_cwe = 1'b0;
            if (c == 0) begin
                access_i  = 1'b1;
                hit_i     = 1'b0;
                dirty_i   = d;
                mem_ack_i = junk ? 1'($urandom % 2) : 1'b0;
            end else begin
                access_i = junk ? 1'($urandom % 2) : 1'b0;
                hit_i    = junk ? 1'($urandom % 2) : 1'b0;
                dirty_i  = junk ? 1'($urandom % 2) : 1'b0;
                if (c <= nw) begin
                    mem_ack_i = (c == nw);
                    e_req = 1'b1; e_we = 1'b1;
                end else if (c <= nw + nrf) begin
                    mem_ack_i = (c == nw + nrf);
                    e_req = 1'b1; e_cwe = mem_ack_i;
                end else begin
                    mem_ack_i = junk ? 1'($urandom % 2) : 1'b0;
                end
            end
            #2;
            checks++;
            if ({mem_req_o, mem_we_o, cache_we_o, stall_o} !== {e_req, e_we, e_cwe, 1'b1}) begin
                errors++;
                $display("FAIL %s miss cyc %0d: req/we/cwe/stall got %b%b%b%b want %b%b%b1",
                         tag, c, mem_req_o, mem_we_o, cache_we_o, stall_o, e_req, e_we, e_cwe);
            end
            if (c == 0) begin
                checks++;
                if ((int'(miss_cnt_o) !== exp_miss) || (int'(stall_cnt_o) !== exp_stall)) begin
                    errors++;
                    $display("FAIL %s counters: got miss %0d stall %0d want %0d %0d",
                             tag, miss_cnt_o, stall_cnt_o, exp_miss, exp_stall);
                end
                exp_miss = sat_inc(exp_miss);
            end
            exp_stall = sat_inc(exp_stall);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; access_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b1; mem_ack_i = 1'b1;
        @(negedge clk);
        #2;
        checks++;
        if ({mem_req_o, mem_we_o, cache_we_o, stall_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset outputs: got %b%b%b%b want 0000",
                     mem_req_o, mem_we_o, cache_we_o, stall_o);
        end
        checks++;
        if ((miss_cnt_o !== 4'd0) || (stall_cnt_o !== 4'd0)) begin
            errors++;
            $display("FAIL reset counters: got %0d %0d want 0 0", miss_cnt_o, stall_cnt_o);
        end
        apply_reset();
        do_idle(2, 1'b0, "post_reset");
    endtask

    task automatic test_hit();
        do_idle(5, 1'b1, "hit");
    endtask

    task automatic test_clean_miss();
        do_miss(1'b0, 0, 3, 1'b0, "clean_miss");
        do_idle(1, 1'b0, "clean_after");
    endtask

    task automatic test_dirty_miss();
        do_miss(1'b1, 2, 2, 1'b0, "dirty_miss");
        do_idle(1, 1'b0, "dirty_after");
    endtask

    task automatic test_reset_mid_rf();
        @(negedge clk);
        access_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        access_i = 1'b0; hit_i = 1'b0;
        #2;
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid enter_rf: req got %b want 1", mem_req_o);
        end
        #1 rst_i = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, cache_we_o, stall_o} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid async outputs: got %b%b%b%b want 0000",
                     mem_req_o, mem_we_o, cache_we_o, stall_o);
        end
        checks++;
        if ((miss_cnt_o !== 4'd0) || (stall_cnt_o !== 4'd0)) begin
            errors++;
            $display("FAIL rst_mid async counters: got %0d %0d want 0 0", miss_cnt_o, stall_cnt_o);
        end
        rst_i = 1'b0;
        exp_miss  = 0;
        exp_stall = 0;
        #0.5;
        checks++;
        if ({mem_req_o, stall_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid state_idle: req/stall got %b%b want 00", mem_req_o, stall_o);
        end
        @(negedge clk);
        mem_ack_i = 1'b1;
        #2;
        checks++;
        if ({mem_req_o, cache_we_o, stall_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid late_ack: req/cwe/stall got %b%b%b want 000",
                     mem_req_o, cache_we_o, stall_o);
        end
        do_miss(1'b0, 0, 2, 1'b0, "rst_mid_recover");
    endtask

    task automatic test_saturation();
        int want;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            do_miss(1'b0, 0, 1, 1'b0, "sat");
        end
        do_idle(1, 1'b0, "sat_idle");
`ifdef STALL_PERF_CNT_EN
        want = 15;
`else
        want = 0;
`endif
        checks++;
        if ((int'(miss_cnt_o) !== want) || (int'(stall_cnt_o) !== want)) begin
            errors++;
            $display("FAIL saturation: got miss %0d stall %0d want %0d %0d",
                     miss_cnt_o, stall_cnt_o, want, want);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_idle($urandom_range(1, 3), 1'b0, "rand_idle");
            end else begin
                do_miss(1'($urandom % 2), $urandom_range(1, 4), $urandom_range(1, 4),
                        1'b1, "rand_miss");
            end
        end
        do_idle(1, 1'b0, "rand_end");
    endtask

    initial begin
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_reset_mid_rf();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
